// File: rtl/uart_link_switch.sv
// uart_link_switch: crossbar for NUM_PORTS master/slave UART segment pairs.
// Route tables are validated as permutations and applied only when every line is idle.
module uart_link_switch #(
   parameter  int NUM_PORTS             = 2,
   parameter  int UART_CLOCKS_PER_PULSE = 5208,
   parameter  int FRAME_BITS            = 10,
   localparam int SEL_W                 = $clog2(NUM_PORTS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       m_tx,
   input  logic [NUM_PORTS-1:0]       s_tx,
   output logic [NUM_PORTS-1:0]       m_rx,
   output logic [NUM_PORTS-1:0]       s_rx,
   input  logic [NUM_PORTS*SEL_W-1:0] cfg_route,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic                       cfg_err,
   output logic                       route_pending,
   output logic                       link_busy,
   output logic [NUM_PORTS-1:0]       err_sticky,
   input  logic                       err_clr
);
   localparam int L         = 2 * NUM_PORTS;
   localparam int FRAME_LEN = FRAME_BITS * UART_CLOCKS_PER_PULSE;
   localparam int CNT_W     = $clog2(FRAME_LEN);

   function automatic logic [NUM_PORTS*SEL_W-1:0] rst_route();
      rst_route = '0;
      for (int i = 0; i < NUM_PORTS; i++) rst_route[i*SEL_W +: SEL_W] = SEL_W'((i + 1) % NUM_PORTS);
   endfunction
   localparam logic [NUM_PORTS*SEL_W-1:0] ROUTE_RST = rst_route();

   typedef enum logic [1:0] {IDLE, FRAME, BRK} trk_t;

   logic [L-1:0] sync1, line, last, armed, start, brk_in, busy, fwd;
   logic [1:0] rdy;
   trk_t st [L];
   trk_t st_n [L];
   logic [CNT_W-1:0] cnt [L];
   logic [CNT_W-1:0] cnt_n [L];
   logic [NUM_PORTS*SEL_W-1:0] route, shadow;
   logic [NUM_PORTS-1:0] used, m_nxt, s_nxt, fm, fs;
   logic pending, in_range, perm_ok;

   // A line is forwarded only once it has been seen idle after reset, so a
   // frame cut by reset never leaks out half-formed.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= '1;
         line  <= '1;
         last  <= '1;
         armed <= '0;
         rdy   <= '0;
      end else begin
         sync1 <= {s_tx, m_tx};
         line  <= sync1;
         last  <= line;
         rdy   <= {rdy[0], 1'b1};
         armed <= armed | (line & {L{rdy[1]}});
      end

   assign fwd = line | ~armed;
   assign fm  = fwd[NUM_PORTS-1:0];
   assign fs  = fwd[L-1:NUM_PORTS];

   always_comb begin
      for (int i = 0; i < L; i++) begin
         start[i]  = st[i] == IDLE && armed[i] && last[i] && !line[i];
         brk_in[i] = st[i] == FRAME && cnt[i] == '0 && !line[i];
         busy[i]   = st[i] != IDLE;
         st_n[i]   = st[i];
         cnt_n[i]  = cnt[i];
         if (start[i]) begin
            st_n[i]  = FRAME;
            cnt_n[i] = CNT_W'(FRAME_LEN - 1);
         end else if (st[i] == FRAME) begin
            cnt_n[i] = cnt[i] == '0 ? cnt[i] : cnt[i] - 1'b1;
            st_n[i]  = cnt[i] != '0 ? FRAME : (line[i] ? IDLE : BRK);
         end else if (st[i] == BRK && line[i]) begin
            st_n[i] = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
         end
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
      end

   assign link_busy = |busy;

   always_comb begin
      used     = '0;
      in_range = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         in_range = in_range && (32'(cfg_route[i*SEL_W +: SEL_W]) < NUM_PORTS);
         used[cfg_route[i*SEL_W +: SEL_W]] = 1'b1;
      end
      perm_ok = in_range && &used;
   end

   // The swap also waits out a start edge being detected this cycle, so a
   // frame's first bit and its remainder always share one route.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         route   <= ROUTE_RST;
         shadow  <= ROUTE_RST;
         pending <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_valid && !pending && !perm_ok;
         if (cfg_valid && !pending && perm_ok) begin
            shadow  <= cfg_route;
            pending <= 1'b1;
         end else if (pending && !link_busy && !(|start)) begin
            route   <= shadow;
            pending <= 1'b0;
         end
      end

   assign cfg_ready     = !pending;
   assign route_pending = pending;

   always_comb begin
      s_nxt = '1;
      m_nxt = '1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         s_nxt[route[i*SEL_W +: SEL_W]] = fm[i];
         m_nxt[i] = fs[route[i*SEL_W +: SEL_W]];
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         m_rx       <= '1;
         s_rx       <= '1;
         err_sticky <= '0;
      end else begin
         m_rx       <= m_nxt;
         s_rx       <= s_nxt;
         err_sticky <= brk_in[NUM_PORTS-1:0] | (err_sticky & ~{NUM_PORTS{err_clr}});
      end
endmodule

// File: tb/tb_uart_link_switch.sv
// tb_uart_link_switch: directed + randomized checks of routing, deferred route
// swaps, table validation, break detection and reset on 2- and 4-port switches.
module tb_uart_link_switch;
   localparam int CPP = 4;
   localparam int FB  = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] m2, s2, mr2, sr2, cr2, err2;
   logic       cv2, crdy2, cerr2, pend2, busy2, eclr2;
   logic [3:0] m4, s4, mr4, sr4, err4;
   logic [7:0] cr4;
   logic       cv4, crdy4, cerr4, pend4, busy4, eclr4;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;
   int r2 [2];
   int r4 [4];
   logic [3:0] h2 [$];
   logic [7:0] h4 [$];

   uart_link_switch #(.NUM_PORTS(2), .UART_CLOCKS_PER_PULSE(CPP), .FRAME_BITS(FB)) u2 (
      .clk(clk), .rst(rst), .m_tx(m2), .s_tx(s2), .m_rx(mr2), .s_rx(sr2),
      .cfg_route(cr2), .cfg_valid(cv2), .cfg_ready(crdy2), .cfg_err(cerr2),
      .route_pending(pend2), .link_busy(busy2), .err_sticky(err2), .err_clr(eclr2));

   uart_link_switch #(.NUM_PORTS(4), .UART_CLOCKS_PER_PULSE(CPP), .FRAME_BITS(FB)) u4 (
      .clk(clk), .rst(rst), .m_tx(m4), .s_tx(s4), .m_rx(mr4), .s_rx(sr4),
      .cfg_route(cr4), .cfg_valid(cv4), .cfg_ready(crdy4), .cfg_err(cerr4),
      .route_pending(pend4), .link_busy(busy4), .err_sticky(err4), .err_clr(eclr4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected rx = tx seen three clocks earlier, permuted by the model route.
   task automatic step();
      logic [3:0] a;
      logic [7:0] b;
      logic [1:0] es2, em2;
      logic [3:0] es4, em4;
      h2.push_back({s2, m2});
      h4.push_back({s4, m4});
      if (h2.size() > 3) void'(h2.pop_front());
      if (h4.size() > 3) void'(h4.pop_front());
      @(posedge clk);
      #1;
      if (chk_on && h2.size() == 3) begin
         a = h2[0];
         b = h4[0];
         es2 = '1;
         es4 = '1;
         for (int i = 0; i < 2; i++) begin
            es2[r2[i]] = a[i];
            em2[i] = a[2 + r2[i]];
         end
         for (int i = 0; i < 4; i++) begin
            es4[r4[i]] = b[i];
            em4[i] = b[4 + r4[i]];
         end
         chk("s_rx2", sr2, es2);
         chk("m_rx2", mr2, em2);
         chk("s_rx4", sr4, es4);
         chk("m_rx4", mr4, em4);
      end
   endtask

   task automatic idle(input int n);
      m2 = '1; s2 = '1; m4 = '1; s4 = '1;
      repeat (n) step();
   endtask

   task automatic rand_steps(input int n);
      repeat (n) begin
         m2 = 2'($urandom); s2 = 2'($urandom);
         m4 = 4'($urandom); s4 = 4'($urandom);
         step();
      end
   endtask

   function automatic logic fbit(input logic [7:0] d, input int k);
      int bi;
      bi = k / CPP;
      return bi == 0 ? 1'b0 : (bi == FB - 1 ? 1'b1 : d[bi-1]);
   endfunction

   task automatic wait_swap(input string tag);
      int n;
      n = 0;
      while (pend2 && n < 60) begin
         step();
         n++;
      end
      chk(tag, pend2, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [7:0] d, tbl;
      int cntv [4];
      int pa [4];
      int t, j;
      bit perm;
      m2 = '1; s2 = '1; m4 = '1; s4 = '1;
      cr2 = '0; cv2 = 0; eclr2 = 0; cr4 = '0; cv4 = 0; eclr4 = 0;
      r2 = '{1, 0};
      r4 = '{1, 2, 3, 0};
      repeat (3) step();
      chk("rst_s_rx", sr2, 2'b11);
      chk("rst_m_rx", mr2, 2'b11);
      chk("rst_cfg_ready", crdy2, 1'b1);
      chk("rst_pending", pend2, 1'b0);
      chk("rst_cfg_err", cerr2, 1'b0);
      chk("rst_err_sticky", err2, 2'b00);
      chk("rst_busy", busy2, 1'b0);
      chk("rst_s_rx4", sr4, 4'hF);
      rst = 0;
      chk_on = 1;
      idle(5);

      // byte 0x55 on m_tx[0] and a random byte on s_tx[1] under the reset cross-link
      d = 8'($urandom);
      for (int k = 0; k < FB * CPP; k++) begin
         m2[0] = fbit(8'h55, k);
         s2[1] = fbit(d, k);
         step();
         chk("s_rx0_idle", sr2[0], 1'b1);
         if (k >= 3) chk("busy_in_frame", busy2, 1'b1);
      end
      idle(10);
      chk("busy_after_frame", busy2, 1'b0);

      rand_steps(200);
      idle(60);
      chk("busy2_quiet", busy2, 1'b0);
      chk("busy4_quiet", busy4, 1'b0);
      eclr2 = 1; step(); eclr2 = 0;
      chk("err_cleared", err2, 2'b00);

      // identity table offered mid-frame is deferred until the frame ends
      d = 8'($urandom);
      for (int k = 0; k < FB * CPP; k++) begin
         m2[0] = fbit(d, k);
         if (k == 10) begin cv2 = 1; cr2 = 2'b10; end
         step();
         cv2 = 0;
         if (k == 10) begin
            chk("accept_pending", pend2, 1'b1);
            chk("accept_ready", crdy2, 1'b0);
            chk("accept_no_err", cerr2, 1'b0);
         end
         if (k > 10) chk("pending_held", pend2, 1'b1);
      end
      m2 = '1;
      step();
      chk("pending_held_41", pend2, 1'b1);
      wait_swap("swap_identity");
      r2 = '{0, 1};
      idle(4);
      rand_steps(100);
      idle(60);

      // offers while pending are ignored without error
      d = 8'($urandom);
      for (int k = 0; k < FB * CPP; k++) begin
         m2[1] = fbit(d, k);
         if (k == 5) begin cv2 = 1; cr2 = 2'b01; end
         if (k == 8) begin cv2 = 1; cr2 = 2'b00; end
         step();
         cv2 = 0;
         if (k == 8) begin
            chk("ignored_no_err", cerr2, 1'b0);
            chk("ignored_pending", pend2, 1'b1);
         end
      end
      m2 = '1;
      wait_swap("swap_cross");
      r2 = '{1, 0};
      idle(4);

      // table validation on the 4-port switch
      for (int n = 0; n < 9; n++) begin
         if (n == 0) tbl = {2'd3, 2'd2, 2'd2, 2'd0};
         else if (n % 2 == 1) begin
            pa = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
               j = $urandom_range(i, 0);
               t = pa[i]; pa[i] = pa[j]; pa[j] = t;
            end
            for (int i = 0; i < 4; i++) tbl[2*i +: 2] = 2'(pa[i]);
         end else tbl = 8'($urandom);
         cntv = '{0, 0, 0, 0};
         for (int i = 0; i < 4; i++) cntv[tbl[2*i +: 2]]++;
         perm = cntv[0] == 1 && cntv[1] == 1 && cntv[2] == 1 && cntv[3] == 1;
         cv4 = 1; cr4 = tbl;
         step();
         cv4 = 0;
         chk("cfg_err_pulse", cerr4, !perm);
         chk("cfg_pending4", pend4, perm);
         step();
         chk("cfg_err_gone", cerr4, 1'b0);
         chk("cfg_pending4_clr", pend4, 1'b0);
         if (perm) for (int i = 0; i < 4; i++) r4[i] = int'(tbl[2*i +: 2]);
         idle(3);
         rand_steps(30);
         idle(60);
      end

      // long low on master 1 becomes a break
      eclr2 = 1; step(); eclr2 = 0;
      chk("err_pre_break", err2, 2'b00);
      for (int k = 0; k < 60; k++) begin
         m2[1] = 1'b0;
         step();
         if (k == 30) chk("err_in_frame", err2, 2'b00);
         if (k == 45) chk("err_on_break", err2, 2'b10);
         if (k == 59) chk("busy_in_break", busy2, 1'b1);
      end
      idle(5);
      chk("break_released", busy2, 1'b0);
      chk("err_holds", err2, 2'b10);
      eclr2 = 1; step(); eclr2 = 0;
      chk("err_clr", err2, 2'b00);

      // err_clr coincident with a fresh break on master 0
      for (int k = 0; k < 60; k++) begin
         m2[0] = 1'b0;
         step();
      end
      chk("err0_set", err2, 2'b01);
      idle(10);
      for (int k = 0; k < 60; k++) begin
         m2[0] = 1'b0;
         if (k == 42) eclr2 = 1;
         step();
         eclr2 = 0;
         if (k == 41) chk("err0_before", err2[0], 1'b1);
         if (k == 42) chk("err0_set_wins", err2[0], 1'b1);
         if (k == 43) chk("err0_after", err2[0], 1'b1);
      end
      idle(10);

      // reset mid-frame with a table pending
      for (int k = 0; k < 15; k++) begin
         m2[0] = fbit(8'h00, k);
         if (k == 5) begin cv2 = 1; cr2 = 2'b10; end
         step();
         cv2 = 0;
         if (k == 5) chk("pend_before_rst", pend2, 1'b1);
      end
      chk_on = 0;
      rst = 1;
      m2[0] = 1'b0;
      step();
      chk("rst_mid_s_rx", sr2, 2'b11);
      chk("rst_mid_m_rx", mr2, 2'b11);
      chk("rst_mid_pending", pend2, 1'b0);
      chk("rst_mid_ready", crdy2, 1'b1);
      chk("rst_mid_busy", busy2, 1'b0);
      chk("rst_mid_err", err2, 2'b00);
      repeat (2) step();
      rst = 0;
      r2 = '{1, 0};
      r4 = '{1, 2, 3, 0};
      for (int k = 0; k < 10; k++) begin
         step();
         chk("no_partial_s_rx", sr2, 2'b11);
         chk("no_partial_busy", busy2, 1'b0);
      end
      idle(6);
      chk_on = 1;
      rand_steps(100);
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
